// File: rtl/pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// pipeline_hazard_ctrl
//
// Stall/flush controller for the 5-stage MIPS pipeline. It sits beside the
// ID stage and merges three hazard sources into one set of pipeline
// controls:
//   - load-use RAW hazards (EX-stage load feeding an ID-stage source)
//   - taken-branch flushes of IF/ID
//   - a multi-cycle mul/div unit. This block sequences that unit and holds
//     HI/LO consumers in ID until the result has been written.
//
// Optional feature macro: HAZ_STALL_CNT_EN
//   When defined, stall_cycles counts stall cycles and saturates at all-ones.
//   When undefined, the counter is absent and stall_cycles is tied to zero.
//
// Ports:
//   clk, rst            single clock; synchronous active-high reset
//   ID_EX_MemRead       EX-stage instruction is a load
//   ID_EX_RegisterRt    load destination register
//   IF_ID_RegisterRs/Rt ID-stage source registers
//   branch_taken        ID-stage branch resolved taken
//   ex_is_muldiv        EX-stage instruction is mult/multu/div/divu
//   ex_is_div           qualifies ex_is_muldiv (1 = div, 0 = mul)
//   id_uses_hilo        ID instruction reads or writes HI/LO
//   stall_mux           insert bubble into ID/EX
//   IF_ID_Write         IF/ID register enable
//   PC_Write            PC enable
//   IF_ID_Flush         zero the IF/ID register
//   md_busy             mul/div unit not idle (registered)
//   hilo_we             one-cycle HI/LO write strobe (registered)
//   stall_cycles        saturating stall-cycle count
// ---------------------------------------------------------------------------
module pipeline_hazard_ctrl #(
  parameter int MUL_LAT = 4,
  parameter int DIV_LAT = 12,
  parameter int CNT_W   = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             ID_EX_MemRead,
  input  logic [4:0]       ID_EX_RegisterRt,
  input  logic [4:0]       IF_ID_RegisterRs,
  input  logic [4:0]       IF_ID_RegisterRt,
  input  logic             branch_taken,
  input  logic             ex_is_muldiv,
  input  logic             ex_is_div,
  input  logic             id_uses_hilo,
  output logic             stall_mux,
  output logic             IF_ID_Write,
  output logic             PC_Write,
  output logic             IF_ID_Flush,
  output logic             md_busy,
  output logic             hilo_we,
  output logic [CNT_W-1:0] stall_cycles
);

  // The latency counter is at least 4 bits and wide enough to hold LAT-2.
  localparam int MAX_LAT = (DIV_LAT > MUL_LAT) ? DIV_LAT : MUL_LAT;
  localparam int MD_CW   = ($clog2(MAX_LAT) > 4) ? $clog2(MAX_LAT) : 4;

  // BUSY lasts LAT-1 cycles: the load value LAT-2 counts down to zero and
  // the zero cycle itself is the last BUSY cycle.
  localparam logic [MD_CW-1:0] MUL_LOAD = MD_CW'(MUL_LAT - 2);
  localparam logic [MD_CW-1:0] DIV_LOAD = MD_CW'(DIV_LAT - 2);

  typedef enum logic [1:0] {
    MD_IDLE = 2'd0,
    MD_BUSY = 2'd1,
    MD_DONE = 2'd2
  } md_state_t;

  md_state_t        md_state_r;
  logic [MD_CW-1:0] md_cnt_r;
  logic             md_busy_r;
  logic             hilo_we_r;

  logic load_use_s;
  logic md_start_s;
  logic md_hazard_s;
  logic stall_s;

  // Hazard detection. Register $0 is hard-wired to zero, so it never stalls.
  // The second operation of a back-to-back mul/div pair also lands here: it
  // uses HI/LO and is held in ID until the unit returns to idle.
  always_comb begin
    load_use_s  = ID_EX_MemRead
                  && (ID_EX_RegisterRt != 5'd0)
                  && ((ID_EX_RegisterRt == IF_ID_RegisterRs)
                      || (ID_EX_RegisterRt == IF_ID_RegisterRt));
    md_start_s  = (md_state_r == MD_IDLE) && ex_is_muldiv;
    md_hazard_s = id_uses_hilo && ((md_state_r != MD_IDLE) || md_start_s);
    stall_s     = load_use_s || md_hazard_s;
  end

  // Pipeline control outputs, priority stall > flush > run. A stalled branch
  // is not flushed because it re-resolves in the following cycle.
  always_comb begin
    stall_mux   = 1'b0;
    IF_ID_Write = 1'b1;
    PC_Write    = 1'b1;
    IF_ID_Flush = 1'b0;
    if (stall_s) begin
      stall_mux   = 1'b1;
      IF_ID_Write = 1'b0;
      PC_Write    = 1'b0;
      IF_ID_Flush = 1'b0;
    end else if (branch_taken) begin
      stall_mux   = 1'b0;
      IF_ID_Write = 1'b1;
      PC_Write    = 1'b1;
      IF_ID_Flush = 1'b1;
    end else begin
      stall_mux   = 1'b0;
      IF_ID_Write = 1'b1;
      PC_Write    = 1'b1;
      IF_ID_Flush = 1'b0;
    end
  end

  // Mul/div sequencer. md_busy and hilo_we are registered alongside the
  // state so each is a clean flop output that tracks the state it decodes.
  // A mul/div request outside IDLE is ignored; ID stalls such requests.
  always_ff @(posedge clk) begin
    if (rst) begin
      md_state_r <= MD_IDLE;
      md_cnt_r   <= {MD_CW{1'b0}};
      md_busy_r  <= 1'b0;
      hilo_we_r  <= 1'b0;
    end else begin
      case (md_state_r)
        MD_IDLE: begin
          if (md_start_s) begin
            md_state_r <= MD_BUSY;
            md_cnt_r   <= ex_is_div ? DIV_LOAD : MUL_LOAD;
            md_busy_r  <= 1'b1;
            hilo_we_r  <= 1'b0;
          end else begin
            md_state_r <= MD_IDLE;
            md_cnt_r   <= md_cnt_r;
            md_busy_r  <= 1'b0;
            hilo_we_r  <= 1'b0;
          end
        end
        MD_BUSY: begin
          if (md_cnt_r != {MD_CW{1'b0}}) begin
            md_state_r <= MD_BUSY;
            md_cnt_r   <= md_cnt_r - {{(MD_CW-1){1'b0}}, 1'b1};
            md_busy_r  <= 1'b1;
            hilo_we_r  <= 1'b0;
          end else begin
            md_state_r <= MD_DONE;
            md_cnt_r   <= md_cnt_r;
            md_busy_r  <= 1'b1;
            hilo_we_r  <= 1'b1;
          end
        end
        MD_DONE: begin
          md_state_r <= MD_IDLE;
          md_cnt_r   <= md_cnt_r;
          md_busy_r  <= 1'b0;
          hilo_we_r  <= 1'b0;
        end
        default: begin
          md_state_r <= MD_IDLE;
          md_cnt_r   <= {MD_CW{1'b0}};
          md_busy_r  <= 1'b0;
          hilo_we_r  <= 1'b0;
        end
      endcase
    end
  end

  assign md_busy = md_busy_r;
  assign hilo_we = hilo_we_r;

`ifdef HAZ_STALL_CNT_EN
  logic [CNT_W-1:0] stall_cnt_r;

  // Saturating count of cycles in which the pipeline front end was stalled.
  always_ff @(posedge clk) begin
    if (rst) begin
      stall_cnt_r <= {CNT_W{1'b0}};
    end else if (stall_s && (stall_cnt_r != {CNT_W{1'b1}})) begin
      stall_cnt_r <= stall_cnt_r + CNT_W'(1'b1);
    end else begin
      stall_cnt_r <= stall_cnt_r;
    end
  end

  assign stall_cycles = stall_cnt_r;
`else
  assign stall_cycles = {CNT_W{1'b0}};
`endif

endmodule

// File: tb/tb_pipeline_hazard_ctrl.sv
// ---------------------------------------------------------------------------
// Directed testbench for pipeline_hazard_ctrl (MUL_LAT=4, DIV_LAT=12,
// CNT_W=4). Each step drives the inputs for one cycle on the falling edge
// and checks every output shortly after, against hand-written expectations.
// ---------------------------------------------------------------------------
module tb_pipeline_hazard_ctrl;

  logic       clk;
  logic       rst;
  logic       ID_EX_MemRead;
  logic [4:0] ID_EX_RegisterRt;
  logic [4:0] IF_ID_RegisterRs;
  logic [4:0] IF_ID_RegisterRt;
  logic       branch_taken;
  logic       ex_is_muldiv;
  logic       ex_is_div;
  logic       id_uses_hilo;
  logic       stall_mux;
  logic       IF_ID_Write;
  logic       PC_Write;
  logic       IF_ID_Flush;
  logic       md_busy;
  logic       hilo_we;
  logic [3:0] stall_cycles;

  int n_checks = 0;
  int n_fail   = 0;
  logic [3:0] exp_cnt = 4'd0;

  pipeline_hazard_ctrl #(
    .MUL_LAT(4),
    .DIV_LAT(12),
    .CNT_W  (4)
  ) dut (
    .clk             (clk),
    .rst             (rst),
    .ID_EX_MemRead   (ID_EX_MemRead),
    .ID_EX_RegisterRt(ID_EX_RegisterRt),
    .IF_ID_RegisterRs(IF_ID_RegisterRs),
    .IF_ID_RegisterRt(IF_ID_RegisterRt),
    .branch_taken    (branch_taken),
    .ex_is_muldiv    (ex_is_muldiv),
    .ex_is_div       (ex_is_div),
    .id_uses_hilo    (id_uses_hilo),
    .stall_mux       (stall_mux),
    .IF_ID_Write     (IF_ID_Write),
    .PC_Write        (PC_Write),
    .IF_ID_Flush     (IF_ID_Flush),
    .md_busy         (md_busy),
    .hilo_we         (hilo_we),
    .stall_cycles    (stall_cycles)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One cycle: drive inputs, check all outputs for this cycle, then advance
  // the expected stall count for the next cycle.
  task automatic step(input logic r, input logic mr, input logic [4:0] ert,
                      input logic [4:0] rs, input logic [4:0] rt, input logic bt,
                      input logic md, input logic dv, input logic uh,
                      input logic e_stall, input logic e_flush,
                      input logic e_busy, input logic e_we, input string tag);
    @(negedge clk);
    rst              = r;
    ID_EX_MemRead    = mr;
    ID_EX_RegisterRt = ert;
    IF_ID_RegisterRs = rs;
    IF_ID_RegisterRt = rt;
    branch_taken     = bt;
    ex_is_muldiv     = md;
    ex_is_div        = dv;
    id_uses_hilo     = uh;
    #1;
    check({tag, ".stall_mux"},    {31'd0, stall_mux},    {31'd0, e_stall});
    check({tag, ".IF_ID_Write"},  {31'd0, IF_ID_Write},  {31'd0, ~e_stall});
    check({tag, ".PC_Write"},     {31'd0, PC_Write},     {31'd0, ~e_stall});
    check({tag, ".IF_ID_Flush"},  {31'd0, IF_ID_Flush},  {31'd0, e_flush});
    check({tag, ".md_busy"},      {31'd0, md_busy},      {31'd0, e_busy});
    check({tag, ".hilo_we"},      {31'd0, hilo_we},      {31'd0, e_we});
    check({tag, ".stall_cycles"}, {28'd0, stall_cycles}, {28'd0, exp_cnt});
`ifdef HAZ_STALL_CNT_EN
    if (r) exp_cnt = 4'd0;
    else if (e_stall && exp_cnt != 4'd15) exp_cnt = exp_cnt + 4'd1;
    else exp_cnt = exp_cnt;
`else
    exp_cnt = 4'd0;
`endif
  endtask

  initial begin
    rst = 1'b1; ID_EX_MemRead = 1'b0; ID_EX_RegisterRt = 5'd0;
    IF_ID_RegisterRs = 5'd0; IF_ID_RegisterRt = 5'd0; branch_taken = 1'b0;
    ex_is_muldiv = 1'b0; ex_is_div = 1'b0; id_uses_hilo = 1'b0;
    repeat (2) @(posedge clk);

    // Reset state: run values, idle unit, zero count.
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "reset");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "idle");

    // Load-use hazards.
    step(1'b0, 1'b1, 5'd9, 5'd9, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "lu_rs");
    step(1'b0, 1'b0, 5'd9, 5'd9, 5'd2, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lu_after");
    step(1'b0, 1'b1, 5'd9, 5'd3, 5'd9, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "lu_rt");
    step(1'b0, 1'b1, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lu_r0");
    step(1'b0, 1'b1, 5'd9, 5'd3, 5'd4, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "lu_nomatch");

    // Branch flush, and stall taking priority over flush.
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, "br_flush");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "br_after");
    step(1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "br_stall");

    // mult in EX at cycle 0 with mflo in ID.
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "mul_c0");
    for (int c = 1; c <= 3; c++)
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "mul_busy");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "mul_c4");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, "mul_c5");

    // Back-to-back div: second held in ID through cycle 12, in EX at 13.
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, "div1_c0");
    for (int c = 1; c <= 11; c++)
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b0, "div1_busy");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, "div1_c12");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "div2_c13");
    for (int c = 14; c <= 24; c++)
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "div2_busy");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b1, "div2_c25");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "div2_c26");

    // 20 consecutive stall cycles: counter saturates at 15 when enabled.
    for (int c = 0; c < 20; c++)
      step(1'b0, 1'b1, 5'd9, 5'd9, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, "sat_stall");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "sat_hold");
`ifdef HAZ_STALL_CNT_EN
    check("sat_value", {28'd0, stall_cycles}, 32'd15);
`else
    check("sat_value", {28'd0, stall_cycles}, 32'd0);
`endif

    // Reset during cycle 2 of a div: idle next cycle, never a HI/LO write.
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rdiv_c0");
    step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "rdiv_c1");
    step(1'b1, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b1, 1'b0, "rdiv_c2");
    for (int c = 3; c <= 16; c++)
      step(1'b0, 1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0, "rdiv_after");
    check("rdiv_cnt", {28'd0, stall_cycles}, 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/pipeline_hazard_ctrl.md
# pipeline_hazard_ctrl

Central stall/flush controller for the 5-stage MIPS pipeline, sitting beside the ID stage. Merges three hazard sources into one set of pipeline-control outputs: load-use RAW hazards, taken-branch flushes, and a multi-cycle multiply/divide unit. Sequences the mul/div unit with a small state machine and stalls dependent HI/LO consumers until the result is written.

## Interface
Parameters:
- MUL_LAT, 4, total mul cycles from start edge to HI/LO write (≥2)
- DIV_LAT, 12, total div cycles from start edge to HI/LO write (≥2)
- CNT_W, 32, stall-cycle counter width

Ports:
- clk  in  1  single clock, all state on rising edge
- rst  in  1  synchronous, active-high reset
- ID_EX_MemRead  in  1  EX-stage instruction is a load
- ID_EX_RegisterRt  in  5  load destination register
- IF_ID_RegisterRs  in  5  ID-stage source rs
- IF_ID_RegisterRt  in  5  ID-stage source rt
- branch_taken  in  1  ID-stage branch resolved taken
- ex_is_muldiv  in  1  EX-stage instruction is mult/multu/div/divu
- ex_is_div  in  1  qualifies ex_is_muldiv: 1=div, 0=mul
- id_uses_hilo  in  1  ID instruction is mfhi/mflo/mthi/mtlo/mult/div
- stall_mux  out  1  1 = insert bubble into ID/EX
- IF_ID_Write  out  1  IF/ID register enable
- PC_Write  out  1  PC enable
- IF_ID_Flush  out  1  zero IF/ID register
- md_busy  out  1  mul/div state ≠ IDLE (registered)
- hilo_we  out  1  one-cycle HI/LO write strobe
- stall_cycles  out  CNT_W  saturating stall-cycle count

## Operation
- load_use = ID_EX_MemRead & (ID_EX_RegisterRt ≠ 0) & (Rt==Rs | Rt==IF_ID Rt). $0 never stalls.
- md_start = (state==IDLE) & ex_is_muldiv.
- md_hazard = id_uses_hilo & (state≠IDLE | md_start).
- stall = load_use | md_hazard.
- Outputs, priority stall > flush > run:
  - stall: stall_mux=1, IF_ID_Write=0, PC_Write=0, IF_ID_Flush=0 (branch in ID re-resolves next cycle).
  - flush (branch_taken & !stall): stall_mux=0, IF_ID_Write=1, PC_Write=1, IF_ID_Flush=1.
  - run: stall_mux=0, IF_ID_Write=1, PC_Write=1, IF_ID_Flush=0.
- Mul/div FSM, 2-bit state, 4-bit min counter (width fits DIV_LAT-2):
  - IDLE: md_start → BUSY, cnt ← (ex_is_div ? DIV_LAT : MUL_LAT) − 2.
  - BUSY: cnt≠0 → cnt−1; cnt==0 → DONE.
  - DONE: hilo_we=1; → IDLE.
  - ex_is_muldiv outside IDLE ignored (cannot occur legally: ID stalls).
- hilo_we decoded from state (DONE), glitch-free registered source.

## Timing
- stall_mux, IF_ID_Write, PC_Write, IF_ID_Flush: combinational, same cycle as inputs/state.
- Load-use: exactly one stall cycle per hazard (bubble clears ID_EX_MemRead).
- Mul/div: start edge → BUSY for LAT−1 cycles → DONE 1 cycle → IDLE. hilo_we high in cycle LAT after start cycle. mfhi in ID during DONE still stalls; proceeds cycle after.
- Back-to-back mul/div: second op stalls in ID until state returns IDLE, enters EX next cycle.
- Reset values: state=IDLE, cnt=0, md_busy=0, hilo_we=0, stall_cycles=0; combinational outputs evaluate to run values (stall_mux=0, IF_ID_Write=1, PC_Write=1, IF_ID_Flush=0) given deasserted inputs.
- rst mid-operation: FSM to IDLE next edge, no hilo_we pulse, counter cleared.

## Configuration
- HAZ_STALL_CNT_EN defined: stall_cycles increments each cycle stall=1, saturates at 2^CNT_W−1, cleared by rst.
- Undefined: counter logic absent; stall_cycles tied to 0. All other behaviour identical.

## Test plan
- Load $t1 (rt=9) in EX, ID rs=9 → 1 cycle stall_mux=1/PC_Write=0/IF_ID_Write=0, next cycle all run values; same with rt=0 → no stall.
- branch_taken=1, no hazard → IF_ID_Flush=1, PC_Write=1 for one cycle; branch_taken with concurrent load-use → stall only, Flush=0.
- MUL_LAT=4, mult in EX at cycle 0 → md_busy cycles 1–4, hilo_we only in cycle 4, IDLE cycle 5; mflo in ID cycles 0–4 stalls, issues cycle 5.
- div then div back-to-back, DIV_LAT=12 → second div held in ID until cycle 13, enters EX cycle 13, its hilo_we at cycle 25.
- rst asserted cycle 2 of a div → state IDLE, md_busy=0 next cycle, no hilo_we ever, stall_cycles=0.
- With HAZ_STALL_CNT_EN, CNT_W=4: 20 consecutive stall cycles → stall_cycles=15 (saturated); without macro → 0.
